// File: rtl/dtcore32_regfile_mp.sv
// dtcore32_regfile_mp: multi-read-port register file with a sequential hardware clear.
// Reset (or a clear request) zeroes every entry, one entry per cycle. Writes are
// dropped and all reads return zero while the clear is in progress.
module dtcore32_regfile_mp #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       regfile_wr_en_i,
    input  logic [ADDR_W-1:0]          dest_reg_i,
    input  logic [DATA_W-1:0]          reg_wr_data_i,
    input  logic [NUM_RD*ADDR_W-1:0]   src_reg_i,
    output logic [NUM_RD*DATA_W-1:0]   src_reg_rd_data_o,
    input  logic                       clr_req_i,
    output logic                       clr_busy_o,
    output logic                       clr_done_o
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              done_q, done_d;

    logic              busy;
    logic              wr_to_zero;
    logic              wr_ok;

    assign busy       = (state_q == ST_CLEAR);
    assign wr_to_zero = (ZERO_REG != 0) && (dest_reg_i == '0);
    assign wr_ok      = !busy && regfile_wr_en_i && !wr_to_zero;

    assign clr_busy_o = busy;
    assign clr_done_o = done_q;

    // State, clear counter and done-pulse registers; reset starts a clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic: IDLE waits for a request, CLEAR walks every entry once.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (clr_req_i) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            ST_CLEAR: begin
                cnt_d = cnt_q + ADDR_W'(1);
                if (cnt_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    // Storage array (no reset): the clear sweep has priority over normal writes.
    always_ff @(posedge clk_i) begin
        if (busy) begin
            mem[cnt_q] <= '0;
        end else if (wr_ok) begin
            mem[dest_reg_i] <= reg_wr_data_i;
        end
    end

    // Combinational read ports with optional same-cycle forwarding.
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] src;
        logic [DATA_W-1:0] rd;

        assign src = src_reg_i[k*ADDR_W +: ADDR_W];

        // Priority: clear blanking, then hardwired zero, then bypass, then array.
        always_comb begin
            rd = mem[src];
            if ((BYPASS != 0) && wr_ok && (dest_reg_i == src)) begin
                rd = reg_wr_data_i;
            end
            if ((ZERO_REG != 0) && (src == '0)) begin
                rd = '0;
            end
            if (busy) begin
                rd = '0;
            end
        end

        assign src_reg_rd_data_o[k*DATA_W +: DATA_W] = rd;
    end

endmodule

// File: tb/tb_dtcore32_regfile_mp.sv
// Directed bench for dtcore32_regfile_mp: a forwarding instance and a
// non-forwarding instance share the same stimulus.
module tb_dtcore32_regfile_mp;

    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic [4:0]  dest;
    logic [31:0] wdata;
    logic [9:0]  src;
    logic        clr_req;

    logic [63:0] rd_a, rd_b;
    logic        busy_a, busy_b, done_a, done_b;

    int check_cnt = 0;
    int pass_cnt  = 0;
    int n;
    int dones;

    dtcore32_regfile_mp #(.BYPASS(1)) dut (
        .clk_i(clk), .rst_ni(rst_n), .regfile_wr_en_i(wr_en), .dest_reg_i(dest),
        .reg_wr_data_i(wdata), .src_reg_i(src), .src_reg_rd_data_o(rd_a),
        .clr_req_i(clr_req), .clr_busy_o(busy_a), .clr_done_o(done_a)
    );

    dtcore32_regfile_mp #(.BYPASS(0)) dut_nb (
        .clk_i(clk), .rst_ni(rst_n), .regfile_wr_en_i(wr_en), .dest_reg_i(dest),
        .reg_wr_data_i(wdata), .src_reg_i(src), .src_reg_rd_data_o(rd_b),
        .clr_req_i(clr_req), .clr_busy_o(busy_b), .clr_done_o(done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic set_src(input logic [4:0] a0, input logic [4:0] a1);
        src = {a1, a0};
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Follow a clear from its first busy sample to completion, counting busy samples.
    // At sample index inject, a write to x3 and a repeat clear request are applied.
    task automatic wait_clear(input string tag, input int inject);
        n = 0;
        dones = 0;
        while (busy_a && n < 100) begin
            if (done_a) dones++;
            if (n == inject) begin
                clr_req = 1'b1; wr_en = 1'b1; dest = 5'd3; wdata = 32'h0000_0001;
            end
            if (n == inject + 1) begin
                clr_req = 1'b0; wr_en = 1'b0;
            end
            if (n == 15) begin
                set_src(5'd3, 5'd5);
                #1;
                chk({tag, "_mid_rd0"}, rd_a[31:0], 32'h0);
                chk({tag, "_mid_rd1"}, rd_a[63:32], 32'h0);
            end
            step();
            n++;
        end
        chk({tag, "_busy_cycles"}, 32'(n), 32'd32);
        chk({tag, "_no_early_done"}, 32'(dones), 32'd0);
        chk({tag, "_done_pulse"}, 32'(done_a), 32'd1);
        step();
        chk({tag, "_done_single"}, 32'(done_a), 32'd0);
        chk({tag, "_idle"}, 32'(busy_a), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; dest = '0; wdata = '0; src = '0; clr_req = 1'b0;

        // Reset state and the power-up clear.
        #22;
        chk("rst_busy", 32'(busy_a), 32'd1);
        chk("rst_done", 32'(done_a), 32'd0);
        rst_n = 1'b1;
        #1;
        wait_clear("init", -1);
        set_src(5'd5, 5'd31);
        #1;
        chk("init_rd0", rd_a[31:0], 32'h0);
        chk("init_rd1", rd_a[63:32], 32'h0);

        // Write x5, read on both ports next cycle.
        wr_en = 1'b1; dest = 5'd5; wdata = 32'hDEAD_BEEF;
        step();
        wr_en = 1'b0;
        set_src(5'd5, 5'd5);
        #1;
        chk("x5_rd0", rd_a[31:0], 32'hDEAD_BEEF);
        chk("x5_rd1", rd_a[63:32], 32'hDEAD_BEEF);

        // Writes to x0 are dropped and x0 always reads zero.
        wr_en = 1'b1; dest = 5'd0; wdata = 32'hFFFF_FFFF;
        set_src(5'd0, 5'd0);
        #1;
        chk("x0_same_bp", rd_a[31:0], 32'h0);
        chk("x0_same_nb", rd_b[31:0], 32'h0);
        step();
        wr_en = 1'b0;
        #1;
        chk("x0_next_bp", rd_a[31:0], 32'h0);
        chk("x0_next_nb", rd_b[31:0], 32'h0);

        // Forwarding: old x7 = 0x11111111, then write 0x12345678 while reading x7.
        wr_en = 1'b1; dest = 5'd7; wdata = 32'h1111_1111;
        step();
        wdata = 32'h1234_5678;
        set_src(5'd5, 5'd7);
        #1;
        chk("bypass_on", rd_a[63:32], 32'h1234_5678);
        chk("bypass_off", rd_b[63:32], 32'h1111_1111);
        chk("bypass_other_port", rd_a[31:0], 32'hDEAD_BEEF);
        step();
        wr_en = 1'b0;
        #1;
        chk("x7_after_bp", rd_a[63:32], 32'h1234_5678);
        chk("x7_after_nb", rd_b[63:32], 32'h1234_5678);

        // Requested clear with a write and a repeat request while it runs.
        wr_en = 1'b1; dest = 5'd3; wdata = 32'hA5A5_A5A5;
        step();
        wr_en = 1'b0;
        set_src(5'd3, 5'd3);
        #1;
        chk("x3_written", rd_a[31:0], 32'hA5A5_A5A5);
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        wait_clear("req", 5);
        set_src(5'd3, 5'd7);
        #1;
        chk("req_x3_zero", rd_a[31:0], 32'h0);
        chk("req_x7_zero", rd_a[63:32], 32'h0);
        chk("req_x3_zero_nb", rd_b[31:0], 32'h0);

        // Reset asserted at clear counter 10 aborts the clear without a done pulse.
        wr_en = 1'b1; dest = 5'd9; wdata = 32'hCAFE_F00D;
        step();
        wr_en = 1'b0;
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            if (done_a) dones++;
            step();
        end
        chk("abort_busy_before", 32'(busy_a), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy_in_rst", 32'(busy_a), 32'd1);
        chk("abort_done_in_rst", 32'(done_a), 32'd0);
        step();
        step();
        if (done_a) dones++;
        chk("abort_no_done", 32'(dones), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        wait_clear("abort", -1);
        set_src(5'd9, 5'd5);
        #1;
        chk("abort_x9_zero", rd_a[31:0], 32'h0);
        chk("abort_x5_zero", rd_a[63:32], 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/dtcore32_regfile_mp.md
DTCORE32_REGFILE_MP -- requirements
Module: dtcore32_regfile_mp

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, register index width; DEPTH = 2**ADDR_W entries.
REQ-003 SHALL have parameter NUM_RD, default 2, number of independent read ports (1..4).
REQ-004 SHALL have parameter ZERO_REG, default 1, 1 = entry 0 hardwired to zero.
REQ-005 SHALL have parameter BYPASS, default 1, 1 = same-cycle write-to-read forwarding.
REQ-006 SHALL have port clk_i  input  1  single clock; all state updates on rising edge.
REQ-007 SHALL have port rst_ni  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port regfile_wr_en_i  input  1  write enable.
REQ-009 SHALL have port dest_reg_i  input  ADDR_W  write index.
REQ-010 SHALL have port reg_wr_data_i  input  DATA_W  write data.
REQ-011 SHALL have port src_reg_i  input  NUM_RD*ADDR_W  read indices, port k at bits [k*ADDR_W +: ADDR_W].
REQ-012 SHALL have port src_reg_rd_data_o  output  NUM_RD*DATA_W  read data, port k at bits [k*DATA_W +: DATA_W].
REQ-013 SHALL have port clr_req_i  input  1  request a full sequential clear.
REQ-014 SHALL have port clr_busy_o  output  1  high while clear in progress.
REQ-015 SHALL have port clr_done_o  output  1  one-cycle pulse on clear completion.

Function
REQ-016 SHALL implement storage as DEPTH x DATA_W array without reset on the array itself.
REQ-017 SHALL implement clear FSM with states IDLE and CLEAR and a clear counter of ADDR_W bits.
REQ-018 SHALL, in CLEAR, write zero to entry[counter] each cycle and increment counter; DEPTH cycles total.
REQ-019 SHALL, in CLEAR with counter == DEPTH-1, pulse clr_done_o for that same cycle's next edge output (registered, high exactly one cycle after last entry cleared) and go to IDLE.
REQ-020 SHALL, in IDLE with clr_req_i high, go to CLEAR with counter = 0 on next edge.
REQ-021 SHALL ignore clr_req_i while in CLEAR (no restart, no extension).
REQ-022 SHALL drive clr_busy_o = 1 exactly when state is CLEAR.
REQ-023 SHALL, in IDLE, write reg_wr_data_i to entry[dest_reg_i] on rising edge when regfile_wr_en_i = 1, except dest_reg_i == 0 with ZERO_REG = 1 (dropped).
REQ-024 SHALL drop all writes while clr_busy_o = 1 (no queuing).
REQ-025 SHALL read combinationally: port k data = entry[src k], latency 0.
REQ-026 SHALL return 0 on port k when ZERO_REG = 1 and src k == 0, regardless of write or bypass.
REQ-027 SHALL, when BYPASS = 1, IDLE, regfile_wr_en_i = 1 and dest_reg_i == src k (and not suppressed by REQ-026), return reg_wr_data_i on port k in the same cycle.
REQ-028 SHALL return 0 on all read ports while clr_busy_o = 1.
REQ-029 SHALL allow all NUM_RD ports to address the same entry simultaneously with identical results.

Reset
REQ-030 SHALL, on rst_ni low, asynchronously set state = CLEAR, counter = 0, clr_done_o = 0; clr_busy_o = 1 during and immediately after reset.
REQ-031 SHALL, after rst_ni rises, clear all DEPTH entries (DEPTH cycles) then pulse clr_done_o; array contents are zero thereafter.
REQ-032 SHALL, on rst_ni low mid-clear or mid-write, abort and restart from counter = 0 after release.

Verification
REQ-033 SHALL cover: release reset, count edges -> clr_busy_o high 32 cycles, clr_done_o single pulse, then all reads = 0.
REQ-034 SHALL cover: write x5 = 0xDEADBEEF, next cycle read port0=x5, port1=x5 -> both 0xDEADBEEF.
REQ-035 SHALL cover: write x0 = 0xFFFFFFFF with port0 src=x0 same cycle and next cycle -> 0 both cycles.
REQ-036 SHALL cover: BYPASS=1, write x7 = 0x12345678 while port1 src=x7 -> port1 = 0x12345678 same cycle; BYPASS=0 -> old x7 value.
REQ-037 SHALL cover: x3 = 0xA5A5A5A5, pulse clr_req_i, write x3 = 1 during clear, clr_req_i again mid-clear -> single 32-cycle clear, x3 = 0 after done.
REQ-038 SHALL cover: assert rst_ni low at clear counter 10 -> clr_done_o never pulses for aborted clear; full 32-cycle clear restarts after release.
